// File: rtl/dcache_flush_if.sv
// Bus between the D$ flush sequencer and its surroundings: LSU command/status,
// tag/state read port, writeback request channel and dirty-bit clear.
interface dcache_flush_if #(
   parameter int NUM_SETS    = 64,
   parameter int NUM_WAYS    = 4,
   parameter int TAG_BITS    = 20,
   parameter int OFFSET_BITS = 6
);
   localparam int SET_BITS = $clog2(NUM_SETS);
   localparam int WAY_BITS = $clog2(NUM_WAYS);

   logic                         flush_req;
   logic                         flush_busy;
   logic                         flush_done;
   logic [SET_BITS-1:0]          evict_set;
   logic [NUM_WAYS*TAG_BITS-1:0] wb_tags;
   logic [NUM_WAYS-1:0]          valid_bits;
   logic [NUM_WAYS-1:0]          dirty_bits;
   // wb_req: one line transfers in each cycle with wb_req_valid && wb_req_ready.
   // While valid is high and ready low, addr and way hold; valid only drops
   // without a transfer when rst is asserted.
   logic                         wb_req_valid;
   logic                         wb_req_ready;
   logic [31:0]                  wb_req_addr;
   logic [WAY_BITS-1:0]          wb_req_way;
   logic                         clean_en;
   logic [SET_BITS-1:0]          clean_set;
   logic [WAY_BITS-1:0]          clean_way;

   modport master (
      input  flush_req, wb_tags, valid_bits, dirty_bits, wb_req_ready,
      output flush_busy, flush_done, evict_set, wb_req_valid, wb_req_addr,
             wb_req_way, clean_en, clean_set, clean_way
   );

   modport slave (
      output flush_req, wb_tags, valid_bits, dirty_bits, wb_req_ready,
      input  flush_busy, flush_done, evict_set, wb_req_valid, wb_req_addr,
             wb_req_way, clean_en, clean_set, clean_way
   );
endinterface

// File: rtl/dcache_flush_ctrl.sv
// D$ flush sequencer: walks every set, reads tags/valid/dirty one cycle after
// driving evict_set, and writes back each valid+dirty way lowest-first.
module dcache_flush_ctrl #(
   parameter int NUM_SETS    = 64,
   parameter int NUM_WAYS    = 4,
   parameter int TAG_BITS    = 20,
   parameter int OFFSET_BITS = 6
) (
   input  logic              clk,
   input  logic              rst,
   dcache_flush_if.master    bus,
   output logic [2:0]        dbg_state
);
   localparam int SET_BITS = $clog2(NUM_SETS);
   localparam int WAY_BITS = $clog2(NUM_WAYS);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_CHECK = 3'd2,
      S_ISSUE = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state;
   logic [SET_BITS-1:0] cur_set;
   logic [NUM_WAYS-1:0] pend;
   logic [TAG_BITS-1:0] tag_q [NUM_WAYS];
   logic                busy_q;
   logic                done_q;
   logic                req_valid_q;
   logic [WAY_BITS-1:0] req_way_q;
   logic [31:0]         req_addr_q;

   logic [TAG_BITS-1:0] in_tag [NUM_WAYS];
   logic [NUM_WAYS-1:0] hit;
   logic [NUM_WAYS-1:0] pend_left;
   logic                last_set;
   logic                handshake;

   function automatic logic [WAY_BITS-1:0] low_way(input logic [NUM_WAYS-1:0] v);
      low_way = '0;
      for (int i = NUM_WAYS - 1; i >= 0; i--) begin
         if (v[i]) low_way = WAY_BITS'(i);
      end
   endfunction

   function automatic logic [31:0] line_addr(input logic [TAG_BITS-1:0] tag,
                                             input logic [SET_BITS-1:0] set);
      line_addr = {tag, set, {OFFSET_BITS{1'b0}}};
   endfunction

   always_comb begin
      for (int w = 0; w < NUM_WAYS; w++) begin
         in_tag[w] = bus.wb_tags[w*TAG_BITS +: TAG_BITS];
      end
   end

   // Invalid lines never write back, whatever their dirty bit says.
   assign hit       = bus.valid_bits & bus.dirty_bits;
   assign last_set  = (cur_set == SET_BITS'(NUM_SETS - 1));
   assign handshake = req_valid_q & bus.wb_req_ready;

   always_comb begin
      pend_left            = pend;
      pend_left[req_way_q] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         cur_set     <= '0;
         pend        <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         req_valid_q <= 1'b0;
         req_way_q   <= '0;
         req_addr_q  <= '0;
         for (int w = 0; w < NUM_WAYS; w++) tag_q[w] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.flush_req) begin
                  cur_set <= '0;
                  busy_q  <= 1'b1;
                  state   <= S_READ;
               end
            end
            S_READ: state <= S_CHECK;
            S_CHECK: begin
               for (int w = 0; w < NUM_WAYS; w++) tag_q[w] <= in_tag[w];
               pend <= hit;
               if (|hit) begin
                  state       <= S_ISSUE;
                  req_valid_q <= 1'b1;
                  req_way_q   <= low_way(hit);
                  req_addr_q  <= line_addr(in_tag[low_way(hit)], cur_set);
               end else if (last_set) begin
                  state  <= S_DONE;
                  done_q <= 1'b1;
               end else begin
                  cur_set <= cur_set + SET_BITS'(1);
                  state   <= S_READ;
               end
            end
            S_ISSUE: begin
               if (handshake) begin
                  pend <= pend_left;
                  if (|pend_left) begin
                     req_way_q  <= low_way(pend_left);
                     req_addr_q <= line_addr(tag_q[low_way(pend_left)], cur_set);
                  end else begin
                     req_valid_q <= 1'b0;
                     req_way_q   <= '0;
                     req_addr_q  <= '0;
                     if (last_set) begin
                        state  <= S_DONE;
                        done_q <= 1'b1;
                     end else begin
                        cur_set <= cur_set + SET_BITS'(1);
                        state   <= S_READ;
                     end
                  end
               end
            end
            S_DONE: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // evict_set tracks cur_set through the whole walk so the BRAM read stays on
   // the set being issued; it is forced to 0 only while idle.
   assign bus.flush_busy   = busy_q;
   assign bus.flush_done   = done_q;
   assign bus.evict_set    = busy_q ? cur_set : '0;
   assign bus.wb_req_valid = req_valid_q;
   assign bus.wb_req_addr  = req_addr_q;
   assign bus.wb_req_way   = req_way_q;
   assign bus.clean_en     = handshake;
   assign bus.clean_set    = busy_q ? cur_set : '0;
   assign bus.clean_way    = req_way_q;
   assign dbg_state        = state;
endmodule

// File: tb/tb_dcache_flush_ctrl.sv
// Bench for dcache_flush_ctrl: cache-array environment, schedule model of the
// walk, per-cycle compare, and directed flush scenarios.
module tb_dcache_flush_ctrl;
  localparam int NS = 64;
  localparam int NW = 4;
  localparam int TB = 20;
  localparam int OB = 6;
  localparam int SB = 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dcache_flush_if #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_BITS(TB), .OFFSET_BITS(OB)) bus ();
  logic [2:0] dbg_state;

  dcache_flush_ctrl #(.NUM_SETS(NS), .NUM_WAYS(NW), .TAG_BITS(TB), .OFFSET_BITS(OB)) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- cache array environment ----------------
  logic [NW-1:0] valid_m [NS];
  logic [NW-1:0] dirty_m [NS];
  logic [TB-1:0] tag_m [NS][NW];
  logic cmd_wr = 1'b0, cmd_clr = 1'b0;
  int cmd_set, cmd_way;
  logic cmd_v, cmd_d;
  logic [TB-1:0] cmd_tag;

  always @(posedge clk) begin
    bus.valid_bits <= valid_m[bus.evict_set];
    bus.dirty_bits <= dirty_m[bus.evict_set];
    for (int w = 0; w < NW; w++) bus.wb_tags[w*TB +: TB] <= tag_m[bus.evict_set][w];
    if (bus.clean_en) dirty_m[bus.clean_set][bus.clean_way] = 1'b0;
    if (cmd_clr)
      for (int s = 0; s < NS; s++) begin
        valid_m[s] = '0;
        dirty_m[s] = '0;
        for (int w = 0; w < NW; w++) tag_m[s][w] = '0;
      end
    if (cmd_wr) begin
      valid_m[cmd_set][cmd_way] = cmd_v;
      dirty_m[cmd_set][cmd_way] = cmd_d;
      tag_m[cmd_set][cmd_way]   = cmd_tag;
    end
  end

  // ---------------- schedule model ----------------
  typedef struct {
    int st;
    int en;
    logic [31:0] addr;
    int way;
  } req_t;
  req_t reqs[$];
  logic [31:0] exp_q[$];
  int set_first[NS];
  bit m_active = 0;
  int m_done = 0;
  int cyc = 0;
  int stall_n = 0;

  always @(posedge clk) begin
    int t;
    req_t r;
    if (rst) begin
      m_active = 0;
      reqs.delete();
      exp_q.delete();
    end else if (!m_active && bus.flush_req) begin
      reqs.delete();
      exp_q.delete();
      t = cyc + 1;
      for (int s = 0; s < NS; s++) begin
        set_first[s] = t;
        t += 2;
        for (int w = 0; w < NW; w++)
          if (valid_m[s][w] && dirty_m[s][w]) begin
            r.st = t;
            r.en = t + stall_n;
            r.addr = {tag_m[s][w], SB'(s), {OB{1'b0}}};
            r.way = w;
            reqs.push_back(r);
            exp_q.push_back(r.addr);
            t += 1 + stall_n;
          end
      end
      m_done = t;
      m_active = 1;
    end else if (m_active && cyc == m_done) begin
      m_active = 0;
    end
    cyc = cyc + 1;
  end

  // ---------------- ready driver + per-cycle compare ----------------
  int wait_cnt = 0;
  bit chk_on = 0;
  logic [31:0] obs_addr[$];
  int obs_way[$];
  int obs_hs[$];
  int obs_cset[$];
  int obs_done_n = 0, obs_done_cyc = -1, obs_evict10 = -1;

  task automatic compare_cycle();
    logic e_valid, e_cen, e_done;
    logic [SB-1:0] e_set;
    logic [31:0] e_addr;
    int e_way;
    e_valid = 0; e_cen = 0; e_set = '0; e_addr = '0; e_way = 0;
    e_done = m_active && (cyc == m_done);
    if (m_active) begin
      for (int s = 0; s < NS; s++) if (set_first[s] <= cyc) e_set = SB'(s);
      foreach (reqs[i])
        if (reqs[i].st <= cyc && cyc <= reqs[i].en) begin
          e_valid = 1;
          e_addr = reqs[i].addr;
          e_way = reqs[i].way;
          e_cen = (cyc == reqs[i].en);
        end
    end
    chk("flush_busy", 32'(bus.flush_busy), 32'(m_active));
    chk("flush_done", 32'(bus.flush_done), 32'(e_done));
    chk("evict_set", 32'(bus.evict_set), 32'(e_set));
    chk("wb_req_valid", 32'(bus.wb_req_valid), 32'(e_valid));
    chk("clean_en", 32'(bus.clean_en), 32'(e_cen));
    if (e_valid) begin
      chk("wb_req_addr", bus.wb_req_addr, e_addr);
      chk("wb_req_way", 32'(bus.wb_req_way), 32'(e_way));
      chk("clean_set", 32'(bus.clean_set), 32'(e_set));
      chk("clean_way", 32'(bus.clean_way), 32'(e_way));
    end else if (!m_active) begin
      chk("idle_addr", bus.wb_req_addr, 32'h0);
      chk("idle_clean_set", 32'(bus.clean_set), 32'h0);
      chk("idle_clean_way", 32'(bus.clean_way), 32'h0);
    end
    if (bus.wb_req_valid && bus.wb_req_ready) begin
      obs_addr.push_back(bus.wb_req_addr);
      obs_way.push_back(int'(bus.wb_req_way));
      obs_hs.push_back(cyc);
      obs_cset.push_back(int'(bus.clean_set));
      if (exp_q.size() == 0) chk("sb_extra_req", 32'h1, 32'h0);
      else chk("sb_addr", bus.wb_req_addr, exp_q.pop_front());
    end
    if (bus.flush_done) begin
      obs_done_n++;
      obs_done_cyc = cyc;
    end
    if (bus.flush_busy && bus.evict_set == SB'(10) && obs_evict10 < 0) obs_evict10 = cyc;
  endtask

  always @(negedge clk) begin
    if (bus.wb_req_valid) begin
      if (wait_cnt >= stall_n) begin
        bus.wb_req_ready = 1'b1;
        wait_cnt = 0;
      end else begin
        bus.wb_req_ready = 1'b0;
        wait_cnt++;
      end
    end else begin
      bus.wb_req_ready = 1'b0;
      wait_cnt = 0;
    end
    #1;
    if (chk_on) compare_cycle();
  end

  // ---------------- driver tasks ----------------
  task automatic set_line(input int s, input int w, input logic v, input logic d,
                          input logic [TB-1:0] tag);
    @(negedge clk);
    cmd_set = s; cmd_way = w; cmd_v = v; cmd_d = d; cmd_tag = tag;
    cmd_wr = 1'b1;
    @(negedge clk);
    cmd_wr = 1'b0;
  endtask

  task automatic clear_all();
    @(negedge clk);
    cmd_clr = 1'b1;
    @(negedge clk);
    cmd_clr = 1'b0;
  endtask

  task automatic pulse_flush(output int t);
    @(negedge clk);
    bus.flush_req = 1'b1;
    t = cyc;
    @(negedge clk);
    bus.flush_req = 1'b0;
  endtask

  task automatic reset_obs();
    obs_addr.delete(); obs_way.delete(); obs_hs.delete(); obs_cset.delete();
    obs_done_n = 0; obs_done_cyc = -1; obs_evict10 = -1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_active || bus.flush_busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_timeout"}, 32'(n < 400), 32'h1);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int t, t2, n;
    rst = 1'b1;
    bus.flush_req = 1'b0;
    clear_all();
    repeat (2) @(negedge clk);
    #2;
    chk("rst_busy", 32'(bus.flush_busy), 32'h0);
    chk("rst_done", 32'(bus.flush_done), 32'h0);
    chk("rst_valid", 32'(bus.wb_req_valid), 32'h0);
    chk("rst_evict", 32'(bus.evict_set), 32'h0);
    chk("rst_addr", bus.wb_req_addr, 32'h0);
    chk("rst_clean_en", 32'(bus.clean_en), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    chk_on = 1;

    // clean cache
    reset_obs();
    stall_n = 0;
    pulse_flush(t);
    wait_idle("clean");
    chk("clean_done_cyc", 32'(obs_done_cyc - t), 32'd129);
    chk("clean_done_n", 32'(obs_done_n), 32'd1);
    chk("clean_nreq", 32'(obs_addr.size()), 32'd0);

    // single dirty line, ready stalled 3 cycles
    reset_obs();
    stall_n = 3;
    set_line(5, 2, 1'b1, 1'b1, 20'hABCDE);
    pulse_flush(t);
    wait_idle("single");
    chk("single_done_cyc", 32'(obs_done_cyc - t), 32'd133);
    chk("single_nreq", 32'(obs_addr.size()), 32'd1);
    chk("single_addr", (obs_addr.size() > 0) ? obs_addr[0] : 32'h0, 32'hABCDE140);
    chk("single_way", (obs_way.size() > 0) ? 32'(obs_way[0]) : 32'hFF, 32'd2);
    chk("single_clean_set", (obs_cset.size() > 0) ? 32'(obs_cset[0]) : 32'hFF, 32'd5);
    chk("single_dirty_cleared", 32'(dirty_m[5][2]), 32'h0);

    // three ways of set 9, ready tied high
    reset_obs();
    stall_n = 0;
    clear_all();
    set_line(9, 0, 1'b1, 1'b1, 20'h11111);
    set_line(9, 1, 1'b1, 1'b1, 20'h22222);
    set_line(9, 3, 1'b1, 1'b1, 20'h33333);
    pulse_flush(t);
    wait_idle("multi");
    chk("multi_nreq", 32'(obs_way.size()), 32'd3);
    if (obs_way.size() == 3) begin
      chk("multi_way0", 32'(obs_way[0]), 32'd0);
      chk("multi_way1", 32'(obs_way[1]), 32'd1);
      chk("multi_way2", 32'(obs_way[2]), 32'd3);
      chk("multi_hs0", 32'(obs_hs[0] - t), 32'd21);
      chk("multi_hs2", 32'(obs_hs[2] - t), 32'd23);
      chk("multi_addr2", obs_addr[2], 32'h33333240);
    end
    chk("multi_read10", 32'(obs_evict10 - t), 32'd24);
    chk("multi_done_cyc", 32'(obs_done_cyc - t), 32'd132);

    // invalid but dirty line in set 0
    reset_obs();
    clear_all();
    set_line(0, 1, 1'b0, 1'b1, 20'h00005);
    pulse_flush(t);
    wait_idle("invalid");
    chk("invalid_nreq", 32'(obs_addr.size()), 32'd0);
    chk("invalid_done_cyc", 32'(obs_done_cyc - t), 32'd129);

    // rst during an ISSUE stall, then a fresh flush
    reset_obs();
    clear_all();
    set_line(5, 2, 1'b1, 1'b1, 20'hABCDE);
    stall_n = 5;
    pulse_flush(t);
    n = 0;
    while (!bus.wb_req_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_valid_timeout", 32'(n < 100), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    chk("rstmid_busy", 32'(bus.flush_busy), 32'h0);
    chk("rstmid_valid", 32'(bus.wb_req_valid), 32'h0);
    chk("rstmid_evict", 32'(bus.evict_set), 32'h0);
    chk("rstmid_clean_en", 32'(bus.clean_en), 32'h0);
    repeat (3) @(negedge clk);
    chk("rstmid_no_done", 32'(obs_done_n), 32'd0);
    chk("rstmid_no_hs", 32'(obs_addr.size()), 32'd0);
    chk("rstmid_still_dirty", 32'(dirty_m[5][2]), 32'h1);
    reset_obs();
    stall_n = 0;
    pulse_flush(t);
    chk("restart_evict0", 32'(bus.evict_set), 32'h0);
    wait_idle("restart");
    chk("restart_nreq", 32'(obs_addr.size()), 32'd1);
    chk("restart_addr", (obs_addr.size() > 0) ? obs_addr[0] : 32'h0, 32'hABCDE140);
    chk("restart_done_cyc", 32'(obs_done_cyc - t), 32'd130);

    // second flush_req mid-walk is ignored
    reset_obs();
    set_line(5, 2, 1'b1, 1'b1, 20'hABCDE);
    pulse_flush(t);
    repeat (48) @(negedge clk);
    pulse_flush(t2);
    wait_idle("double");
    chk("double_done_n", 32'(obs_done_n), 32'd1);
    chk("double_done_cyc", 32'(obs_done_cyc - t), 32'd130);
    chk("double_nreq", 32'(obs_addr.size()), 32'd1);

    chk_on = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/dcache_flush_ctrl.md
# dcache_flush_ctrl

Sequencer that walks every D$ set and way on a flush command, reads back tags and state, and issues one writeback request per valid and dirty line to the memory-side writeback port. It sits beside the LSU tag/data stages. It drives the writeback-tag read port (evict set index) and clears dirty bits as writebacks are accepted. It reports busy/done to the LSU so that the flush instruction can retire.

## Interface
- NUM_SETS, 64: D$ sets; power of two.
- NUM_WAYS, 4: D$ ways; power of two, at least 2.
- TAG_BITS, 20: tag width.
- OFFSET_BITS, 6: line byte-offset width. TAG_BITS + log2(NUM_SETS) + OFFSET_BITS = 32.
- SET_BITS and WAY_BITS: localparams, log2 of NUM_SETS and NUM_WAYS.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- flush_req  in  1  start flush. Sampled only in IDLE.
- flush_busy  out  1  high in every non-IDLE state.
- flush_done  out  1  one-cycle pulse when the walk completes.
- evict_set  out  SET_BITS  read address to the tag BRAM port b and the valid/dirty arrays.
- wb_tags  in  NUM_WAYS*TAG_BITS  tags for evict_set, valid 1 cycle after evict_set. Way w is at [w*TAG_BITS +: TAG_BITS].
- valid_bits  in  NUM_WAYS  valid bits for evict_set, same 1-cycle latency.
- dirty_bits  in  NUM_WAYS  dirty bits for evict_set, same 1-cycle latency.
- wb_req_valid  out  1  writeback request.
- wb_req_ready  in  1  writeback accepted when valid && ready.
- wb_req_addr  out  32  line address, {tag, set, OFFSET_BITS'b0}.
- wb_req_way  out  WAY_BITS  way whose data is written back. The data stage reads the line data using this.
- clean_en  out  1  clear dirty bit; equals wb_req_valid && wb_req_ready.
- clean_set  out  SET_BITS  equals the current set.
- clean_way  out  WAY_BITS  equals wb_req_way.

## Operation
- States: IDLE, READ, CHECK, ISSUE, DONE.
- IDLE:
  - If flush_req, set cur_set to 0 and go to READ.
  - Otherwise stay in IDLE; all outputs are 0.
- READ: drive evict_set = cur_set, then go to CHECK.
- CHECK:
  - Capture wb_tags into tag registers and set pend = valid_bits & dirty_bits.
  - If pend is nonzero, go to ISSUE.
  - Else if cur_set == NUM_SETS-1, go to DONE.
  - Else increment cur_set and go to READ.
- ISSUE:
  - Selected way w is the lowest set bit of pend.
  - Drive wb_req_valid = 1, wb_req_way = w, wb_req_addr = {tag[w], cur_set, 0}.
  - Hold all request fields stable while ready is low.
  - On handshake, clear pend[w].
  - If the remaining pend is nonzero, stay in ISSUE; the next way is presented the following cycle.
  - Otherwise go to DONE on the last set, or increment cur_set and go to READ.
- DONE: flush_done = 1 and flush_busy = 1 for one cycle, then go to IDLE.
- Lines with valid=0 are never written back, regardless of dirty.
- evict_set holds cur_set in every non-IDLE state, so BRAM data stays coherent.
- flush_req outside IDLE is ignored, not queued.
- Set counter arithmetic is SET_BITS wide. The last-set compare happens before increment, so the counter never wraps to 0 mid-walk.

## Timing
- Reset: every output is 0 (flush_busy, flush_done, evict_set, wb_req_valid, wb_req_addr, wb_req_way, clean_en, clean_set, clean_way); state = IDLE; cur_set = 0; pend = 0.
- rst mid-operation: return to IDLE the next cycle. No flush_done pulse. Any request in flight is dropped (valid falls). Dirty bits not yet cleaned stay set.
- Request sampled at cycle T: READ for set s is in cycle T+1+2s and CHECK in T+2+2s, plus the accumulated ISSUE cycles.
- A clean cache has flush_done in cycle T+2*NUM_SETS+1.
- Each ISSUE handshake costs 1 cycle plus ready-low stall cycles.
- clean_en is combinational with the handshake cycle; no extra latency.
- flush_req and rst together: rst wins.

## Test plan
- Clean cache (all dirty=0), NUM_SETS=64, flush_req in cycle T:
  - wb_req_valid never asserts.
  - flush_busy is high for cycles T+1..T+129.
  - flush_done is high only in T+129.
- Single dirty line at set 5, way 2, tag 0xABCDE, with ready low for 3 cycles then high:
  - One request with addr 0xABCDE140 and way 2, fields stable across the stall.
  - clean_en pulses once with clean_set=5 and clean_way=2.
  - flush_done in T+133.
- Set 9 with ways 0, 1, 3 valid and dirty, ready tied high:
  - Three consecutive handshakes in order way 0, 1, 3.
  - READ of set 10 follows in the next cycle.
- Way with valid=0 and dirty=1 in set 0: no request is issued, and the walk timing equals the clean case.
- rst asserted during an ISSUE stall:
  - The next cycle shows all outputs 0 and no flush_done.
  - A new flush_req restarts at evict_set=0 and writes back the same line again.
- Second flush_req pulse mid-walk: ignored; exactly one flush_done occurs, at the same cycle as a single-request run.
